dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between the RV32 core load/store unit (port C) and the GEMM accelerator's operand/result mover (port A). Sits between both requesters and the data memory, driving its address/data/mask, active-low chip select and read/write-enable. Round-robin arbitration with a bounded accelerator burst lock; read data is routed back to whichever requester issued the read.

Parameters:
MAX_BURST, 16, max consecutive accelerator grants under acc_lock while the core is also requesting (1..255)
ADDR_W, 32, byte address width; memory word index is addr[ADDR_W-1:2]

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_req / acc_req  in  1  request; holds stable until accepted (req & gnt)
core_we / acc_we  in  1  1=write, 0=read
core_addr / acc_addr  in  ADDR_W  byte address
core_wdata / acc_wdata  in  32  write data
core_mask / acc_mask  in  4  byte-lane enables (write only)
acc_lock  in  1  accelerator requests burst ownership
core_gnt / acc_gnt  out  1  request accepted this cycle
core_rvalid / acc_rvalid  out  1  read data valid
core_rdata / acc_rdata  out  32  read data, 0 when rvalid=0
mem_address  out  32  to memory
mem_data_in  out  32  to memory
mem_rd_wr_en  out  1  1=read, 0=write
mem_bus_cs  out  1  active-low select
mem_mask  out  4  byte lanes
mem_data_out  in  32  from memory (registered in memory at posedge)
mem_valid  in  1  from memory, high the cycle after an accepted read
proto_err  out  1  sticky protocol-error flag
burst_active  out  1  high while in S_ACC_BURST

Behaviour:
- Reset (async, rst_n=0): state S_IDLE, last_winner=ACC, burst_cnt=0, rd_pend cleared, proto_err=0; gnts 0, rvalids 0, rdata 0, mem_bus_cs=1, mem_rd_wr_en=1, mem_address/data_in/mask=0. Pending read is dropped; the returning mem_valid is ignored and does not flag proto_err.
- At most one access per cycle; gnt is combinational from req and registered state; mem_* driven combinationally from the granted request in the same cycle. No grant: mem_bus_cs=1, mem_rd_wr_en=1, other mem_* 0.
- Winner selection: only one req -> that requester. Both: acc if state=S_ACC_BURST and burst_cnt<MAX_BURST; else the requester not equal to last_winner.
- FSM (registered owner): S_IDLE (no grant last cycle), S_CORE, S_ACC, S_ACC_BURST. Core grant -> S_CORE. Acc grant with acc_lock=0 -> S_ACC. Acc grant with acc_lock=1 -> S_ACC_BURST. No grant -> S_IDLE. S_ACC_BURST with acc_lock=0 or acc_req=0 -> leaves per above.
- burst_cnt: increments on each acc grant in S_ACC_BURST while core_req=1, saturating at MAX_BURST; cleared on leaving S_ACC_BURST and on any core grant. With core_req=0 the burst is unbounded.
- last_winner updates on every grant.
- Reads: accepted read in cycle N sets rd_pend{valid,owner}; in N+1, mem_valid=1 -> owner's rvalid=1, rdata=mem_data_out. Back-to-back reads give one rvalid per cycle. Writes: no response; memory commits at the following negedge, so a read accepted in N+1 returns the data written in N.
- proto_err set when mem_valid=1 without pending read, or pending read without mem_valid; cleared only by reset.
- Write mask is passed unchanged; mask=0 write is a legal no-op.

Decomposition:
- dmem_arb_pkg: typedef enum {S_IDLE,S_CORE,S_ACC,S_ACC_BURST} arb_state_e; typedef enum logic {OWN_CORE,OWN_ACC} owner_e; read/write encoding constants MEM_RD=1, MEM_WR=0; CS_ACTIVE=0.
- One sub-module: dmem_arb_rr_pick (combinational winner selection from reqs, state, burst_cnt, last_winner); FSM, counters and read-return in the top.

Test Plan:
- Core only: write 0xDEADBEEF mask 4'hF to 0x10, read 0x10 next cycle -> core_gnt both cycles, core_rvalid one cycle after read with rdata 0xDEADBEEF; acc_rvalid stays 0.
- Both request continuously, acc_lock=0 -> grants alternate C,A,C,A (last_winner reset ACC so core first); 8 cycles give 4 grants each.
- acc_lock=1, MAX_BURST=16, both request -> 16 acc grants (first after any core grant rule), then 1 core grant, then burst resumes; burst_active high throughout acc run.
- Byte write mask 4'b0010 data 0x0000AB00 onto 0x11223344 at 0x20, acc reads -> acc_rdata 0x1122AB44.
- Assert rst_n low the cycle after an accepted acc read -> all outputs at reset values, no acc_rvalid, proto_err=0 after release.
- Force mem_valid=1 with no read pending -> proto_err rises next cycle and stays 1 until rst_n.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE,
    S_ACC,
    S_ACC_BURST
  } arb_state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_ACC
  } owner_e;

  localparam logic MEM_RD    = 1'b1;
  localparam logic MEM_WR    = 1'b0;
  localparam logic CS_ACTIVE = 1'b0;

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Combinational winner selection: round-robin with a bounded accelerator burst.
module dmem_arb_rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       core_req,
  input  logic       acc_req,
  input  arb_state_e state,
  input  logic [7:0] burst_cnt,
  input  owner_e     last_winner,
  output logic       core_win,
  output logic       acc_win
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  // Single requester wins outright; on contention the burst owner keeps the
  // port until its budget runs out, otherwise the previous loser goes next.
  always_comb begin
    core_win = 1'b0;
    acc_win  = 1'b0;
    if (core_req && acc_req) begin
      if (state == S_ACC_BURST && burst_cnt < MAX_CNT) begin
        acc_win = 1'b1;
      end else if (last_winner == OWN_ACC) begin
        core_win = 1'b1;
      end else begin
        acc_win = 1'b1;
      end
    end else begin
      core_win = core_req;
      acc_win  = acc_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core LSU and the GEMM
// accelerator mover, and routes read data back to the issuing requester.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_mask,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  input  logic [3:0]        acc_mask,
  input  logic              acc_lock,
  output logic              core_gnt,
  output logic              acc_gnt,
  output logic              core_rvalid,
  output logic              acc_rvalid,
  output logic [31:0]       core_rdata,
  output logic [31:0]       acc_rdata,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_rd_wr_en,
  output logic              mem_bus_cs,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_valid,
  output logic              proto_err,
  output logic              burst_active
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  arb_state_e state_q, state_d;
  owner_e     last_winner_q;
  owner_e     rd_owner_q;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pend_q;
  logic       proto_err_q;
  logic       core_win, acc_win;
  logic       rsp;

  dmem_arb_rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .core_req    (core_req),
    .acc_req     (acc_req),
    .state       (state_q),
    .burst_cnt   (burst_cnt_q),
    .last_winner (last_winner_q),
    .core_win    (core_win),
    .acc_win     (acc_win)
  );

  // Grants are suppressed while reset is held so the memory stays deselected.
  always_comb begin
    core_gnt     = rst_n & core_win;
    acc_gnt      = rst_n & acc_win;
    mem_bus_cs   = ~CS_ACTIVE;
    mem_rd_wr_en = MEM_RD;
    mem_address  = '0;
    mem_data_in  = '0;
    mem_mask     = '0;
    if (core_gnt) begin
      mem_bus_cs   = CS_ACTIVE;
      mem_rd_wr_en = core_we ? MEM_WR : MEM_RD;
      mem_address  = 32'(core_addr);
      mem_data_in  = core_wdata;
      mem_mask     = core_mask;
    end else if (acc_gnt) begin
      mem_bus_cs   = CS_ACTIVE;
      mem_rd_wr_en = acc_we ? MEM_WR : MEM_RD;
      mem_address  = 32'(acc_addr);
      mem_data_in  = acc_wdata;
      mem_mask     = acc_mask;
    end
  end

  // Next owner state and burst budget. The budget counts every locked acc
  // grant (including the one that opens the burst) made while the core waits,
  // so MAX_BURST bounds the whole consecutive run.
  always_comb begin
    state_d     = S_IDLE;
    burst_cnt_d = '0;
    if (core_gnt) begin
      state_d = S_CORE;
    end else if (acc_gnt) begin
      if (acc_lock) begin
        state_d     = S_ACC_BURST;
        burst_cnt_d = (core_req && burst_cnt_q < MAX_CNT) ? burst_cnt_q + 8'd1
                                                           : burst_cnt_q;
      end else begin
        state_d = S_ACC;
      end
    end
  end

  // Owner state, burst budget and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      burst_cnt_q   <= '0;
      last_winner_q <= OWN_ACC;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      if (core_gnt) begin
        last_winner_q <= OWN_CORE;
      end else if (acc_gnt) begin
        last_winner_q <= OWN_ACC;
      end
    end
  end

  // Outstanding-read tracking and sticky protocol check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_CORE;
      proto_err_q <= 1'b0;
    end else begin
      rd_pend_q   <= (core_gnt & ~core_we) | (acc_gnt & ~acc_we);
      rd_owner_q  <= acc_gnt ? OWN_ACC : OWN_CORE;
      proto_err_q <= proto_err_q | (mem_valid ^ rd_pend_q);
    end
  end

  // Steer returning read data to the requester that issued the read.
  always_comb begin
    rsp          = rd_pend_q & mem_valid;
    core_rvalid  = rsp & (rd_owner_q == OWN_CORE);
    acc_rvalid   = rsp & (rd_owner_q == OWN_ACC);
    core_rdata   = core_rvalid ? mem_data_out : '0;
    acc_rdata    = acc_rvalid ? mem_data_out : '0;
    proto_err    = proto_err_q;
    burst_active = (state_q == S_ACC_BURST);
  end

endmodule
